// File: rtl/mem_data_responder_pkg.sv
// Shared constants and types for the data-memory responder.
package mem_data_responder_pkg;

  localparam int MEM_ADDR_WIDTH_DEF = 10;
  localparam int DATA_WIDTH_DEF     = 32;
  localparam int TRANSFER_WIDTH_DEF = DATA_WIDTH_DEF / 8;
  localparam int MEM_DEPTH_DEF      = 256;
  localparam int RESP_LATENCY_DEF   = 1;

  typedef enum logic {
    RESP_WRITE = 1'b0,
    RESP_READ  = 1'b1
  } resp_kind_e;

  function automatic logic word_in_range(int unsigned idx, int unsigned depth);
    return idx < depth;
  endfunction

endpackage

// File: rtl/mem_resp_pipe.sv
// Fixed-latency response shift register of {valid, kind, data}; every stage advances each cycle.
module mem_resp_pipe
  import mem_data_responder_pkg::*;
#(
  parameter int RESP_LATENCY = RESP_LATENCY_DEF,
  parameter int DATA_WIDTH   = DATA_WIDTH_DEF
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  in_vld,
  input  resp_kind_e            in_kind,
  input  logic [DATA_WIDTH-1:0] in_dat,
  output logic                  out_vld,
  output logic [DATA_WIDTH-1:0] out_dat
);

  logic [RESP_LATENCY-1:0] vld_q, vld_d;
  resp_kind_e              kind_q [RESP_LATENCY];
  resp_kind_e              kind_d [RESP_LATENCY];
  logic [DATA_WIDTH-1:0]   dat_q  [RESP_LATENCY];
  logic [DATA_WIDTH-1:0]   dat_d  [RESP_LATENCY];

  always_comb begin
    vld_d     = '0;
    vld_d[0]  = in_vld;
    kind_d[0] = in_kind;
    dat_d[0]  = in_dat;
    for (int i = 1; i < RESP_LATENCY; i++) begin
      vld_d[i]  = vld_q[i-1];
      kind_d[i] = kind_q[i-1];
      dat_d[i]  = dat_q[i-1];
    end
  end

  // Reset discards anything in flight; those responses are never issued.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_q <= '0;
      for (int i = 0; i < RESP_LATENCY; i++) begin
        kind_q[i] <= RESP_WRITE;
        dat_q[i]  <= '0;
      end
    end else begin
      vld_q <= vld_d;
      for (int i = 0; i < RESP_LATENCY; i++) begin
        kind_q[i] <= kind_d[i];
        dat_q[i]  <= dat_d[i];
      end
    end
  end

  assign out_vld = vld_q[RESP_LATENCY-1];
  assign out_dat = (vld_q[RESP_LATENCY-1] && kind_q[RESP_LATENCY-1] == RESP_READ)
                   ? dat_q[RESP_LATENCY-1] : '0;

endmodule

// File: rtl/mem_data_responder.sv
// Responder end of the req/gnt/rvalid data port: byte-enabled word RAM with a fixed-latency response.
module mem_data_responder
  import mem_data_responder_pkg::*;
#(
  parameter int MEM_ADDR_WIDTH = MEM_ADDR_WIDTH_DEF,
  parameter int DATA_WIDTH     = DATA_WIDTH_DEF,
  parameter int TRANSFER_WIDTH = TRANSFER_WIDTH_DEF,
  parameter int MEM_DEPTH      = MEM_DEPTH_DEF,
  parameter int RESP_LATENCY   = RESP_LATENCY_DEF
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      req_i,
  input  logic                      we_i,
  input  logic [MEM_ADDR_WIDTH-1:0] addr_i,
  input  logic [DATA_WIDTH-1:0]     wdata_i,
  input  logic [TRANSFER_WIDTH-1:0] be_i,
  input  logic                      stall_i,
  output logic                      gnt_o,
  output logic                      rvalid_o,
  output logic [DATA_WIDTH-1:0]     rdata_o
);

  localparam int IDX_W = MEM_ADDR_WIDTH - 2;
  localparam int MEM_W = $clog2(MEM_DEPTH);

  logic [DATA_WIDTH-1:0] mem_q [MEM_DEPTH];
  logic [DATA_WIDTH-1:0] word_d;
  logic [DATA_WIDTH-1:0] rd_dat;
  logic [IDX_W-1:0]      word_idx;
  logic [MEM_W-1:0]      mem_idx;
  logic                  in_range;
  logic                  accept;
  logic                  wr_en;
  logic                  unused_addr_lsb;

  assign unused_addr_lsb = ^addr_i[1:0];
  assign word_idx = addr_i[MEM_ADDR_WIDTH-1:2];
  assign mem_idx  = word_idx[MEM_W-1:0];
  assign in_range = word_in_range(int'(word_idx), MEM_DEPTH);

  assign gnt_o  = req_i & ~stall_i & rst_n;
  assign accept = req_i & gnt_o;
  assign wr_en  = accept & we_i & in_range;

  // Read samples the pre-write array, so program order holds across successive edges.
  always_comb begin
    rd_dat = '0;
    word_d = '0;
    if (in_range) begin
      rd_dat = mem_q[mem_idx];
      word_d = mem_q[mem_idx];
    end
    for (int k = 0; k < TRANSFER_WIDTH; k++) begin
      if (be_i[k]) word_d[8*k +: 8] = wdata_i[8*k +: 8];
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en) mem_q[mem_idx] <= word_d;
  end

  mem_resp_pipe #(
    .RESP_LATENCY (RESP_LATENCY),
    .DATA_WIDTH   (DATA_WIDTH)
  ) u_resp_pipe (
    .clk     (clk),
    .rst_n   (rst_n),
    .in_vld  (accept),
    .in_kind (we_i ? RESP_WRITE : RESP_READ),
    .in_dat  (rd_dat),
    .out_vld (rvalid_o),
    .out_dat (rdata_o)
  );

endmodule
